// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multicycle control path: opcodes, ALU codes,
// datapath select encodings and the sequencer state type.
package riscv_pkg;

    localparam logic [6:0] TYPE_R      = 7'b0110011;
    localparam logic [6:0] TYPE_I_ALU  = 7'b0010011;
    localparam logic [6:0] TYPE_I_LOAD = 7'b0000011;
    localparam logic [6:0] TYPE_S      = 7'b0100011;
    localparam logic [6:0] TYPE_B      = 7'b1100011;
    localparam logic [6:0] TYPE_J      = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } mc_state_t;

    // Immediate format follows the opcode alone, independent of sequencer state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            TYPE_S:  sel = IMM_S;
            TYPE_B:  sel = IMM_B;
            TYPE_J:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: fixed ADD/SUB for address and compare steps, otherwise
// funct3/funct7_5 decode. SUB is only selected for register-register ops.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_rtype,
    output logic [2:0] o_alucontrol
);

    // funct7_5 on an I-type is an immediate bit, so it must not turn addi into sub.
    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        if (i_rtype && i_funct7_5) begin
                            o_alucontrol = ALU_SUB;
                        end else begin
                            o_alucontrol = ALU_ADD;
                        end
                    end
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctl_fsm.sv
// Multicycle control sequencer for the RV32I subset core over a single-port memory.
// Build option MC_CTL_ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP and raise illegal_op.
module mc_ctl_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
`ifdef MC_CTL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       instr_done
);

    mc_state_t  r_state;
    mc_state_t  w_next_state;
    logic       w_mem_req;
    logic       w_memwrite;
    logic       w_adrsrc;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic       w_rtype;
    logic       w_done;
    logic [1:0] w_aluop_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore decode; only mem_ready and zero qualify individual strobes
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_adrsrc     = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_resultsrc  = RES_ALUOUT;
        w_alusrca    = SRCA_PC;
        w_alusrcb    = SRCB_RS2;
        w_aluop      = ALUOP_ADD;
        w_rtype      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                if (mem_ready) begin
                    w_irwrite    = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (op)
                    TYPE_I_LOAD, TYPE_S: w_next_state = S_MEMADR;
                    TYPE_R:              w_next_state = S_EXECUTER;
                    TYPE_I_ALU:          w_next_state = S_EXECUTEI;
                    TYPE_B:              w_next_state = S_BEQ;
                    TYPE_J:              w_next_state = S_JAL;
                    default: begin
`ifdef MC_CTL_ILLEGAL_TRAP_EN
                        w_next_state = S_TRAP;
`else
                        w_next_state = S_FETCH;
                        w_done       = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = SRCA_RS1;
                w_alusrcb = SRCB_IMM;
                if (op == TYPE_I_LOAD) begin
                    w_next_state = S_MEMREAD;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                w_resultsrc  = RES_DATA;
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_adrsrc   = 1'b1;
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXECUTER: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_aluop      = ALUOP_FUNCT;
                w_rtype      = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_aluop      = ALUOP_SUB;
                w_pcwrite    = zero;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_alusrca    = SRCA_OLDPC;
                w_alusrcb    = SRCB_FOUR;
                w_pcwrite    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
`ifdef MC_CTL_ILLEGAL_TRAP_EN
                w_next_state = S_TRAP;
`else
                w_next_state = S_FETCH;
`endif
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Reset withdraws any pending access at once and parks the selects at their FETCH values
    always_comb begin
        if (reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            regwrite   = 1'b0;
            adrsrc     = 1'b0;
            alusrca    = SRCA_PC;
            alusrcb    = SRCB_FOUR;
            resultsrc  = RES_ALURESULT;
            w_aluop_q  = ALUOP_ADD;
            instr_done = 1'b0;
        end else begin
            mem_req    = w_mem_req;
            memwrite   = w_memwrite;
            irwrite    = w_irwrite;
            pcwrite    = w_pcwrite;
            regwrite   = w_regwrite;
            adrsrc     = w_adrsrc;
            alusrca    = w_alusrca;
            alusrcb    = w_alusrcb;
            resultsrc  = w_resultsrc;
            w_aluop_q  = w_aluop;
            instr_done = w_done;
        end
    end

    assign immsrc = imm_sel(op);

`ifdef MC_CTL_ILLEGAL_TRAP_EN
    assign illegal_op = (~reset) & (r_state == S_TRAP);
`endif

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop_q),
        .i_funct3     (funct3),
        .i_funct7_5   (funct7_5),
        .i_rtype      (w_rtype),
        .o_alucontrol (alucontrol)
    );

endmodule
